// File: rtl/seq_slice_comparator_if.sv
// Operand/result handshake bundle for seq_slice_comparator.
// Handshake: an operand set moves when in_valid && in_ready at a rising edge; a result moves when out_valid && out_ready.
interface seq_slice_comparator_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             gt;
    logic             lt;

    // Driven by the comparator.
    modport slave (
        input  in_valid, a, b, signed_mode, flush, out_ready,
        output in_ready, out_valid, eq, gt, lt
    );

    // Driven by the operand producer / result consumer.
    modport master (
        output in_valid, a, b, signed_mode, flush, out_ready,
        input  in_ready, out_valid, eq, gt, lt
    );
endinterface

// File: rtl/seq_slice_comparator.sv
// Sequential magnitude comparator: SLICE bits per cycle, MSB slice first, unsigned or signed.
// Define SEQ_CMP_EARLY_EXIT_EN to finish on the first differing slice instead of always scanning all slices.
module seq_slice_comparator #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_slice_comparator_if.slave bus,
    output logic [1:0]           state_o
);

    localparam int NUM_SLICES = WIDTH / SLICE;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NUM_SLICES - 1);
    localparam logic [SLICE-1:0] MSB_MASK = SLICE'(1) << (SLICE - 1);

    if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_param_check
        $error("seq_slice_comparator: WIDTH must be a positive multiple of SLICE");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e                             state_q;
    logic [NUM_SLICES-1:0][SLICE-1:0]   a_q;
    logic [NUM_SLICES-1:0][SLICE-1:0]   b_q;
    logic                               signed_q;
    logic [IDX_W-1:0]                   idx_q;
    logic                               decided_q;
    logic                               dgt_q;
    logic                               dlt_q;
    logic                               eq_q;
    logic                               gt_q;
    logic                               lt_q;
    logic                               in_ready_q;
    logic                               out_valid_q;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic             slice_gt;
    logic             slice_lt;
    logic             decided_d;
    logic             gt_d;
    logic             lt_d;
    logic             finish_d;

    always_comb begin
        slice_a = a_q[idx_q];
        slice_b = b_q[idx_q];
        // Flipping the sign bit maps two's-complement order onto unsigned order.
        if (signed_q && (idx_q == TOP_IDX)) begin
            slice_a = slice_a ^ MSB_MASK;
            slice_b = slice_b ^ MSB_MASK;
        end
        slice_gt  = (slice_a > slice_b);
        slice_lt  = (slice_a < slice_b);
        decided_d = decided_q | slice_gt | slice_lt;
        gt_d      = decided_q ? dgt_q : slice_gt;
        lt_d      = decided_q ? dlt_q : slice_lt;
`ifdef SEQ_CMP_EARLY_EXIT_EN
        finish_d  = (idx_q == '0) || slice_gt || slice_lt;
`else
        finish_d  = (idx_q == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            idx_q       <= '0;
            decided_q   <= 1'b0;
            dgt_q       <= 1'b0;
            dlt_q       <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            // Abort drops the operation but leaves the last published result intact.
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        signed_q   <= bus.signed_mode;
                        idx_q      <= TOP_IDX;
                        decided_q  <= 1'b0;
                        dgt_q      <= 1'b0;
                        dlt_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    decided_q <= decided_d;
                    dgt_q     <= gt_d;
                    dlt_q     <= lt_d;
                    if (finish_d) begin
                        // Outputs change only here, so they are one-hot for the whole DONE period.
                        eq_q        <= ~decided_d;
                        gt_q        <= gt_d;
                        lt_q        <= lt_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_seq_slice_comparator.sv
// Bench for seq_slice_comparator: directed plan vectors, randomized ops against a
// full-width arithmetic model, backpressure, flush and asynchronous reset scenarios.
module tb_seq_slice_comparator;

    localparam int W = 32;
    localparam int S = 4;
    localparam int N = W / S;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [2:0] exp_q[$];
    int         lat_q[$];
    logic [2:0] last_res;

    seq_slice_comparator_if #(.WIDTH(W)) bus ();

    seq_slice_comparator #(.WIDTH(W), .SLICE(S)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .state_o(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Result packed as {eq, gt, lt}.
    function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        if (sm) begin
            if ($signed(a) == $signed(b)) return 3'b100;
            return ($signed(a) > $signed(b)) ? 3'b010 : 3'b001;
        end
        if (a == b) return 3'b100;
        return (a > b) ? 3'b010 : 3'b001;
    endfunction

    function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        int j;
        d = a ^ b;
        j = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (d[i*S +: S] != '0) break;
            j++;
        end
        if (j == N || !EARLY) return N;
        return j + 1;
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                          input bit rand_ordy, input bit release_done,
                          output logic [2:0] got, output int lat);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.a = a;
        bus.b = b;
        bus.signed_mode = sm;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.signed_mode = 1'($urandom_range(0, 1));
        if (rand_ordy) bus.out_ready = 1'($urandom_range(0, 1));
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 4 * N) begin
            @(posedge clk); #1;
            lat++;
        end
        got = {bus.eq, bus.gt, bus.lt};
        if (release_done) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt} !== 5'b10000)
            $display("FAIL reset_state: got rdy/vld/eq/gt/lt=%b expected 10000",
                     {bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL reset_release: got rdy/vld=%b expected 10", {bus.in_ready, bus.out_valid});
        else n_pass++;
        last_res = 3'b000;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[9] = '{32'h12345678, 32'h12345678, 32'h80000000, 32'h80000000,
                                32'h00000010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        logic [W-1:0] tb[9] = '{32'h12345678, 32'h12345678, 32'h7FFFFFFF, 32'h7FFFFFFF,
                                32'h00000001, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic         ts[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0]   tr[9] = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b001};
        int           te[9] = '{8, 8, 1, 1, 7, 1, 8, 1, 1};
        logic [2:0] got;
        int lat;
        int exp_lat;
        for (int i = 0; i < 9; i++) begin
            run_op(ta[i], tb[i], ts[i], 1'b0, 1'b1, got, lat);
            exp_lat = EARLY ? te[i] : N;
            n_chk++;
            if (got !== tr[i] || lat !== exp_lat)
                $display("FAIL directed_%0d: a=%h b=%h sm=%0d got eq/gt/lt=%b lat=%0d expected %b lat=%0d",
                         i, ta[i], tb[i], ts[i], got, lat, tr[i], exp_lat);
            else n_pass++;
            last_res = tr[i];
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] m;
        logic         sm;
        logic [2:0]   got;
        logic [2:0]   exp_r;
        int           lat;
        int           exp_lat;
        int           k;
        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            sm = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = a;
                2: b = a ^ (W'(1) << $urandom_range(0, W - 1));
                default: begin
                    k = $urandom_range(0, N);
                    m = '1;
                    m = (k == N) ? '0 : (m >> (k * S));
                    b = (a & ~m) | ($urandom & m);
                end
            endcase
            exp_q.push_back(model_res(a, b, sm));
            lat_q.push_back(model_lat(a, b));
            run_op(a, b, sm, 1'b1, 1'b1, got, lat);
            exp_r   = exp_q.pop_front();
            exp_lat = lat_q.pop_front();
            n_chk++;
            if (got !== exp_r || lat !== exp_lat)
                $display("FAIL random_%0d: a=%h b=%h sm=%0d got eq/gt/lt=%b lat=%0d expected %b lat=%0d",
                         i, a, b, sm, got, lat, exp_r, exp_lat);
            else n_pass++;
            last_res = exp_r;
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] got;
        int lat;
        run_op(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, got, lat);
        n_chk++;
        if (got !== 3'b001 || bus.out_valid !== 1'b1)
            $display("FAIL bp_result: got eq/gt/lt=%b vld=%b expected 001 vld=1", got, bus.out_valid);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a = $urandom;
            bus.b = $urandom;
            bus.signed_mode = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n_chk++;
            if ({bus.out_valid, bus.in_ready, bus.eq, bus.gt, bus.lt} !== 5'b10001)
                $display("FAIL bp_hold_%0d: got vld/rdy/eq/gt/lt=%b state=%0d expected 10001",
                         i, {bus.out_valid, bus.in_ready, bus.eq, bus.gt, bus.lt}, dbg_state);
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_chk++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL bp_release: got rdy/vld=%b expected 10", {bus.in_ready, bus.out_valid});
        else n_pass++;
        last_res = 3'b001;
    endtask

    task automatic test_flush();
        logic [2:0] got;
        int lat;
        bit seen;
        run_op(32'h00000055, 32'h00000055, 1'b0, 1'b0, 1'b1, got, lat);
        n_chk++;
        if (got !== 3'b100)
            $display("FAIL flush_setup: got eq/gt/lt=%b expected 100", got);
        else n_pass++;
        // Operand whose first difference is in slice 0, so it is still comparing when flushed.
        bus.a = 32'h00000009;
        bus.b = 32'h00000005;
        bus.signed_mode = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        n_chk++;
        if ({bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt} !== 5'b10100)
            $display("FAIL flush_abort: got rdy/vld/eq/gt/lt=%b expected 10100",
                     {bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt});
        else n_pass++;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_chk++;
        if (seen || bus.in_ready !== 1'b1)
            $display("FAIL flush_no_pulse: got out_valid_seen=%0d rdy=%b expected 0 and 1", seen, bus.in_ready);
        else n_pass++;
        // flush beats in_valid in IDLE: nothing is accepted.
        bus.a = $urandom;
        bus.b = $urandom;
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        n_chk++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL flush_priority: got in_ready=%b expected 1", bus.in_ready);
        else n_pass++;
        run_op(32'd5, 32'd9, 1'b0, 1'b0, 1'b1, got, lat);
        n_chk++;
        if (got !== 3'b001 || lat !== N)
            $display("FAIL flush_followup: got eq/gt/lt=%b lat=%0d expected 001 lat=%0d", got, lat, N);
        else n_pass++;
        last_res = 3'b001;
    endtask

    task automatic test_async_reset();
        logic [2:0] got;
        logic [2:0] exp_r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int lat;
        int exp_lat;
        bit seen;
        run_op(32'h00000010, 32'h00000001, 1'b0, 1'b0, 1'b1, got, lat);
        n_chk++;
        if (got !== 3'b010)
            $display("FAIL arst_setup: got eq/gt/lt=%b expected 010", got);
        else n_pass++;
        bus.a = 32'h00000009;
        bus.b = 32'h00000005;
        bus.signed_mode = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt} !== 5'b10000)
            $display("FAIL arst_immediate: got rdy/vld/eq/gt/lt=%b expected 10000",
                     {bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_chk++;
        if (seen || bus.in_ready !== 1'b1)
            $display("FAIL arst_dropped: got out_valid_seen=%0d rdy=%b expected 0 and 1", seen, bus.in_ready);
        else n_pass++;
        a = $urandom;
        b = $urandom;
        exp_q.push_back(model_res(a, b, 1'b1));
        lat_q.push_back(model_lat(a, b));
        run_op(a, b, 1'b1, 1'b0, 1'b1, got, lat);
        exp_r   = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        n_chk++;
        if (got !== exp_r || lat !== exp_lat)
            $display("FAIL arst_recover: a=%h b=%h got eq/gt/lt=%b lat=%0d expected %b lat=%0d",
                     a, b, got, lat, exp_r, exp_lat);
        else n_pass++;
        last_res = exp_r;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
